// File: rtl/arith_chk_pkg.sv
// Shared types and helpers for the full-adder stimulus/response checker.
//   state_e : checker FSM states
//   VEC_W   : width of one stimulus vector, {cin, y, x}
//   exp_t   : one delay-line entry {vld, vec, c, s}
//   fa_ref  : golden full-adder result {carry, sum} for a vector
package arith_chk_pkg;

    typedef enum logic [1:0] {StIdle, StDrive, StDrain, StDone} state_e;

    localparam int unsigned VEC_W = 3;

    typedef struct packed {
        logic             vld;
        logic [VEC_W-1:0] vec;
        logic             c;
        logic             s;
    } exp_t;

    function automatic logic [1:0] fa_ref(input logic [VEC_W-1:0] vec);
        logic a, b, ci;
        a  = vec[0];
        b  = vec[1];
        ci = vec[2];
        return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/arith_chk_exp_pipe.sv
// Delay line carrying the expected adder response alongside the driven vector.
// Depth LATENCY, so the output lines up with the cycle in which the DUT's
// registered sum/carry for that vector is valid.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear (new run)
//   push_vld   : a vector is currently being driven
//   push_vec   : the driven vector {cin, y, x}
//   pop        : delayed {vld, vec, exp_c, exp_s}
module arith_chk_exp_pipe
    import arith_chk_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push_vld,
    input  logic [VEC_W-1:0] push_vec,
    output exp_t             pop
);

    exp_t stage_q [LATENCY];
    exp_t entry;
    logic [1:0] ref_cs;

    always_comb begin
        ref_cs    = fa_ref(push_vec);
        entry.vld = push_vld;
        entry.vec = push_vec;
        entry.c   = ref_cs[1];
        entry.s   = ref_cs[0];
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= entry;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign pop = stage_q[LATENCY-1];

endmodule

// File: rtl/arith_stim_checker.sv
// Stimulus driver and response checker for a registered 1-bit full adder.
// Sweeps all eight {cin, y, x} vectors SWEEPS times, compares regA/regcout
// against the golden sum/carry LATENCY cycles later, and reports results.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : begin a run (honoured in idle/done only)
//   x, y, cin                : registered operand bits to the adder
//   regA, regcout            : adder sum and carry
//   busy, done, pass         : run status; pass = done with no errors
//   err_count                : mismatching compare cycles, saturating
//   first_fail_vec/_vld      : vector of the first mismatch
// Build option: define ARITH_CHK_XCHECK_EN to compare with !== so X/Z on
// regA/regcout counts as a mismatch (simulation only).
module arith_stim_checker
    import arith_chk_pkg::*;
#(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned SWEEPS  = 4,
    parameter int unsigned ERR_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             x,
    output logic             y,
    output logic             cin,
    input  logic             regA,
    input  logic             regcout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_vld
);

    localparam int unsigned SW_W = (SWEEPS > 1) ? $clog2(SWEEPS) : 1;
    localparam int unsigned DR_W = $clog2(LATENCY + 1);

    state_e           state;
    logic [VEC_W-1:0] vec_cnt;
    logic [SW_W-1:0]  sweep_cnt;
    logic [DR_W-1:0]  drain_cnt;
    logic             drv_vld;
    logic             run_clr;
    logic             last_vec;
    logic             mismatch;
    exp_t             exp_out;

    assign run_clr  = start && ((state == StIdle) || (state == StDone));
    assign last_vec = (&vec_cnt) && (sweep_cnt == SW_W'(SWEEPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            vec_cnt   <= '0;
            sweep_cnt <= '0;
            drain_cnt <= '0;
            drv_vld   <= 1'b0;
            {cin, y, x} <= '0;
        end else begin
            // Operands are only non-zero while driving.
            {cin, y, x} <= '0;
            drv_vld     <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state     <= StDrive;
                        vec_cnt   <= '0;
                        sweep_cnt <= '0;
                        drain_cnt <= '0;
                    end
                end
                StDrive: begin
                    {cin, y, x} <= vec_cnt;
                    drv_vld     <= 1'b1;
                    vec_cnt     <= vec_cnt + 1'b1;
                    if (&vec_cnt) begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                    if (last_vec) begin
                        state     <= StDrain;
                        drain_cnt <= '0;
                    end
                end
                StDrain: begin
                    // LATENCY+1 edges: the last response is compared on the final one.
                    if (drain_cnt == DR_W'(LATENCY)) begin
                        state <= StDone;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    arith_chk_exp_pipe #(
        .LATENCY (LATENCY)
    ) u_exp_pipe (
        .clk      (clk),
        .rst      (rst),
        .clr      (run_clr),
        .push_vld (drv_vld),
        .push_vec ({cin, y, x}),
        .pop      (exp_out)
    );

`ifdef ARITH_CHK_XCHECK_EN
    assign mismatch = (regA !== exp_out.s) || (regcout !== exp_out.c);
`else
    assign mismatch = (regA != exp_out.s) || (regcout != exp_out.c);
`endif

    always_ff @(posedge clk) begin
        if (rst || run_clr) begin
            err_count      <= '0;
            first_fail_vec <= '0;
            first_fail_vld <= 1'b0;
        end else if (exp_out.vld && mismatch) begin
            if (err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
            if (!first_fail_vld) begin
                first_fail_vec <= exp_out.vec;
                first_fail_vld <= 1'b1;
            end
        end
    end

    assign busy = (state == StDrive) || (state == StDrain);
    assign done = (state == StDone);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_arith_stim_checker.sv
// Randomised bench for arith_stim_checker: a behavioural adder with per-vector
// fault masks sits on the DUT side; each run's expected result is predicted
// from the masks and pushed to a queue, and a monitor pops it on done.
module tb_arith_stim_checker;

    localparam int L    = 2;
    localparam int S    = 2;
    localparam int EW   = 4;
    localparam int EMAX = (1 << EW) - 1;

    typedef struct {
        int err;
        int ffv;
        int ffvld;
        int pass;
        int done_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          x, y, cin;
    logic          regA, regcout;
    logic          busy, done, pass;
    logic [EW-1:0] err_count;
    logic [2:0]    first_fail_vec;
    logic          first_fail_vld;

    logic [7:0] fault_s = 8'h00;
    logic [7:0] fault_c = 8'h00;
    logic [2:0] dly [L];

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q [$];
    exp_t mon_e;
    logic done_prev = 1'b0;

    arith_stim_checker #(
        .LATENCY (L),
        .SWEEPS  (S),
        .ERR_W   (EW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .x              (x),
        .y              (y),
        .cin            (cin),
        .regA           (regA),
        .regcout        (regcout),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_vec (first_fail_vec),
        .first_fail_vld (first_fail_vld)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // {carry, sum} is simply the population count of the three input bits.
    function automatic logic [1:0] golden(input logic [2:0] v);
        int tot;
        tot = int'(v[0]) + int'(v[1]) + int'(v[2]);
        return 2'(tot);
    endfunction

    // Behavioural adder with L cycles of latency and optional faults.
    always @(posedge clk) begin
        dly[0] <= {cin, y, x};
        for (int i = 1; i < L; i++) dly[i] <= dly[i-1];
    end

    logic [1:0] g_out;
    always_comb begin
        g_out   = golden(dly[L-1]);
        regA    = g_out[0] ^ fault_s[dly[L-1]];
        regcout = g_out[1] ^ fault_c[dly[L-1]];
    end

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t predict(input logic [7:0] ms, input logic [7:0] mc, input int c0);
        exp_t e;
        int   cnt;
        cnt     = 0;
        e.ffv   = 0;
        e.ffvld = 0;
        for (int n = 0; n < 8 * S; n++) begin
            int v;
            v = n % 8;
            if (ms[v] || mc[v]) begin
                if (cnt == 0) begin
                    e.ffv   = v;
                    e.ffvld = 1;
                end
                cnt++;
            end
        end
        e.err      = (cnt > EMAX) ? EMAX : cnt;
        e.pass     = (cnt == 0) ? 1 : 0;
        e.done_cyc = c0 + 2 + 8 * S + L;
        return e;
    endfunction

    // Monitor: a rising done is the DUT presenting a result.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_cycle", cyc, mon_e.done_cyc);
                check("err_count", int'(err_count), mon_e.err);
                check("first_fail_vld", int'(first_fail_vld), mon_e.ffvld);
                check("first_fail_vec", int'(first_fail_vec), mon_e.ffv);
                check("pass", int'(pass), mon_e.pass);
                check("busy_in_done", int'(busy), 0);
                check("operands_in_done", int'({cin, y, x}), 0);
            end
        end
        done_prev <= done;
    end

    task automatic start_run(input logic [7:0] ms, input logic [7:0] mc);
        @(negedge clk);
        fault_s = ms;
        fault_c = mc;
        exp_q.push_back(predict(ms, mc, cyc));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 8 * S + L + 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        check({name, "_operands"}, int'({cin, y, x}), 0);
        check({name, "_status"}, int'({busy, done, pass}), 0);
        check({name, "_err"}, int'(err_count), 0);
        check({name, "_ff"}, int'({first_fail_vld, first_fail_vec}), 0);
    endtask

    logic [7:0] stuck_c;

    initial begin
        for (int v = 0; v < 8; v++) begin
            logic [1:0] g;
            g = golden(3'(v));
            stuck_c[v] = g[1];
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");

        // Ideal adder.
        start_run(8'h00, 8'h00);
        wait_done();

        // Carry stuck at 0: four failing vectors per sweep, first is 3'b011.
        start_run(8'h00, stuck_c);
        wait_done();

        // Sum inverted: every compare fails, count saturates.
        start_run(8'hFF, 8'h00);
        wait_done();

        // Restart from done clears the previous errors.
        start_run(8'h00, 8'h00);
        wait_done();

        // start pulses in DRIVE and in DRAIN must not disturb the run.
        start_run(8'h24, 8'h81);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8 * S - 3) @(negedge clk);
        check("busy_in_drain", int'(busy), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset while vector 5 is on the operands.
        start_run(8'h00, 8'h10);
        repeat (6) @(negedge clk);
        check("vec_during_drive", int'({cin, y, x}), 5);
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_run_reset");
        repeat (8 * S + L + 5) @(negedge clk);
        check("idle_after_reset", int'({busy, done}), 0);

        // Clean run after the aborted one.
        start_run(8'h00, 8'h00);
        wait_done();

        // Random fault patterns.
        for (int r = 0; r < 6; r++) begin
            logic [7:0] ms, mc;
            ms = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            mc = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            start_run(ms, mc);
            wait_done();
        end

        // start and rst together: reset wins.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_idle("rst_and_start");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
